fmuldiv_arbiter: RTL
====================

# fmuldiv_arbiter

Shares one floating-point multiply/divide unit (fmuldiv, any pipeline configuration) among `n_req` requesters. Each requester has a valid/ready issue port and a valid/ready result port. A round-robin arbiter issues at most one operation per cycle. A tag pipeline matched to the unit's latency routes each result back to its requester's result FIFO. Per-requester credit counters guarantee a FIFO can never overflow, so the shared unit never needs backpressure.

## Interface
Parameters:
- `float`, `svfloat::float32`: floating-point type, identical to the attached unit's type.
- `n_req`, 2: number of requesters, 2..8.
- `latency`, 0: pipeline registers in the attached unit (0..2); equals `plr_pre_mul + plr_post_mul` of the instance.
- `fifo_depth`, 2: result FIFO entries per requester, ≥1.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `[n_req]`: operation offered by requester i.
- `req_ready` out `[n_req]`: operation i accepted this cycle.
- `req_lhs` in `float[n_req]`: left operand per requester.
- `req_rhs` in `float[n_req]`: right operand per requester.
- `resp_valid` out `[n_req]`: result available for requester i.
- `resp_ready` in `[n_req]`: requester i consumes its result.
- `resp_res` out `float[n_req]`: result FIFO head per requester.
- `fu_lhs` out `float`: to unit `lhs`.
- `fu_rhs` out `float`: to unit `rhs`.
- `fu_res` in `float`: from unit `res`.
- `busy` out 1: any tag in flight or any FIFO non-empty.

## Operation
**Eligibility and grant**
- Requester i is eligible when `req_valid[i]` is high and `credit[i] > 0`.
- The grant goes to the first eligible requester, searching from `rr_ptr` upward modulo `n_req`.
- `req_ready[i]` is high only for the granted index. It is combinational from `req_valid`, credit and pointer.
- On a grant to g, `rr_ptr` becomes (g+1) mod n_req. With no grant, `rr_ptr` holds.

**Driving the unit**
- `fu_lhs`/`fu_rhs` carry the granted requester's operands.
- With no grant they are driven to all-zero, so the unit computes a harmless 0·0.

**Credits**
- `credit[i]` is `$clog2(fifo_depth+1)` bits wide. Reset value is `fifo_depth`.
- It decrements on an issue from i and increments on a pop (`resp_valid[i] && resp_ready[i]`).
- Issue and pop in the same cycle leave it unchanged.
- Invariant: `credit[i] + inflight[i] + fifo_count[i] == fifo_depth`. It never underflows or overflows, so there are no overflow checks.

**Tag pipeline**
- The pipeline has `latency` stages of {valid, id}. Stage 0 loads {grant, g}, and tags shift every cycle.
- The tag leaving the last stage (or the current grant when `latency==0`) marks `fu_res` as valid for requester id.
- That result is written into FIFO[id] at the clock edge.

**Result FIFOs**
- Each FIFO has `fifo_depth` entries with wrapping read/write pointers.
- `resp_valid[i]` = FIFO[i] non-empty; `resp_res[i]` = head entry.
- A pop and a push in the same cycle are legal when full or empty: the count is unchanged and the data ordering is preserved.
- There is no bypass: a result is never presented in the cycle it is written.

**Ordering**
- Results for each requester return in issue order.
- Results for different requesters are independent.

## Timing
**Reset values** (while `rst_n` is low, asynchronously)
- `req_ready`=0, `resp_valid`=0, `resp_res`=0, `fu_lhs`=`fu_rhs`=0, `busy`=0.
- `rr_ptr`=0, all credits = `fifo_depth`, all tags invalid, FIFOs empty.

**Latency and throughput**
- An issue accepted in cycle t gives `resp_valid` high in cycle t+latency+1.
- Aggregate throughput is one issue per cycle.
- A single requester sustains one issue per cycle only if `fifo_depth ≥ latency+2`. A credit freed by a pop in cycle p is usable in cycle p+1.

**Reset mid-operation**
- In-flight tags and FIFO contents are discarded.
- Stale outputs from the unit after reset release are ignored, because their tags are invalid.
- No `resp_valid` is raised for operations issued before reset.

**Other boundaries**
- A requester with zero credit sees `req_ready` low even when it is otherwise first in round-robin order. The grant moves to the next eligible requester in the same cycle.

## Test plan
1. **Reset values:** hold `rst_n`=0 with all `req_valid`=1 → every output is 0. Release `rst_n` → requester 0 is granted in the first cycle.
2. **Single-requester streaming** (latency 0, depth 2): requester 0 issues 0x3FC00000·0x40000000 every cycle with `resp_ready`=1 → `req_ready[0]` stays high. `resp_res[0]`=0x40400000 appears from cycle 1 onward, one result per cycle.
3. **Fair arbitration:** both requesters continuously valid → grants alternate 0,1,0,1. Each requester's results return in issue order.
4. **Credit stall** (depth 2): `resp_ready[0]`=0 → exactly two issues from requester 0, then `req_ready[0]`=0 while requester 1 is granted every cycle. Raise `resp_ready[0]` for one cycle → one further grant to requester 0 the following cycle.
5. **Latency 2:** issue in cycle t → `resp_valid` in t+3. Interleaved requesters 0/1/0 → correct routing, and `busy` stays high until the last pop.
6. **Reset mid-flight:** pull `rst_n` low with 2 operations in flight and 1 queued result → all `resp_valid`=0 immediately. After release, no spurious results appear and all credits equal `fifo_depth`.

Source files
------------

// File: rtl/fmuldiv_arbiter.sv
// Round-robin sharing of one fmuldiv unit among n_req requesters, with a
// latency-matched tag pipeline and credit-protected per-requester result FIFOs.

package svfloat;
  typedef logic [31:0] float32;
endpackage

module fmuldiv_arbiter #(
  parameter type         float      = svfloat::float32,
  parameter int unsigned n_req      = 2,
  parameter int unsigned latency    = 0,
  parameter int unsigned fifo_depth = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [n_req-1:0] req_valid,
  output logic [n_req-1:0] req_ready,
  input  float             req_lhs [n_req],
  input  float             req_rhs [n_req],
  output logic [n_req-1:0] resp_valid,
  input  logic [n_req-1:0] resp_ready,
  output float             resp_res [n_req],
  output float             fu_lhs,
  output float             fu_rhs,
  input  float             fu_res,
  output logic             busy
);

  localparam int unsigned PW = (n_req > 1) ? $clog2(n_req) : 1;
  localparam int unsigned CW = $clog2(fifo_depth + 1);
  localparam int unsigned AW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;

  logic [PW-1:0]    rr_ptr;
  logic [CW-1:0]    credit [n_req];
  logic [n_req-1:0] eligible;
  logic             gnt_valid;
  logic [PW-1:0]    gnt_id;

  logic             out_valid;
  logic [PW-1:0]    out_id;
  logic             tags_busy;

  logic [n_req-1:0] push;
  logic [n_req-1:0] pop;
  float             mem    [n_req][fifo_depth];
  logic [AW-1:0]    rd_ptr [n_req];
  logic [AW-1:0]    wr_ptr [n_req];
  logic [CW-1:0]    count  [n_req];

  // (base + k) mod n_req, valid for base, k < n_req
  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base,
                                             input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= n_req) s = s - n_req;
    return s[PW-1:0];
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(fifo_depth - 1)) ? '0 : p + AW'(1);
  endfunction

  // Eligibility is masked during reset so req_ready reads 0 while rst_n is low.
  always_comb begin
    eligible  = '0;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    for (int unsigned i = 0; i < n_req; i++)
      eligible[i] = rst_n && req_valid[i] && (credit[i] != '0);
    for (int unsigned k = 0; k < n_req; k++) begin
      if (!gnt_valid && eligible[rr_index(rr_ptr, k)]) begin
        gnt_valid = 1'b1;
        gnt_id    = rr_index(rr_ptr, k);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < n_req; i++)
      req_ready[i] = gnt_valid && (gnt_id == PW'(i));
    fu_lhs = gnt_valid ? req_lhs[gnt_id] : '0;
    fu_rhs = gnt_valid ? req_rhs[gnt_id] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      for (int unsigned i = 0; i < n_req; i++)
        credit[i] <= CW'(fifo_depth);
    end else begin
      if (gnt_valid)
        rr_ptr <= rr_index(gnt_id, 1);
      for (int unsigned i = 0; i < n_req; i++) begin
        if (req_ready[i] && !pop[i])
          credit[i] <= credit[i] - CW'(1);
        else if (!req_ready[i] && pop[i])
          credit[i] <= credit[i] + CW'(1);
      end
    end
  end

  generate
    if (latency == 0) begin : g_no_pipe
      assign out_valid = gnt_valid;
      assign out_id    = gnt_id;
      assign tags_busy = 1'b0;
    end else begin : g_pipe
      logic          tag_v  [latency];
      logic [PW-1:0] tag_id [latency];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned s = 0; s < latency; s++) begin
            tag_v[s]  <= 1'b0;
            tag_id[s] <= '0;
          end
        end else begin
          tag_v[0]  <= gnt_valid;
          tag_id[0] <= gnt_id;
          for (int unsigned s = 1; s < latency; s++) begin
            tag_v[s]  <= tag_v[s-1];
            tag_id[s] <= tag_id[s-1];
          end
        end
      end

      always_comb begin
        tags_busy = 1'b0;
        for (int unsigned s = 0; s < latency; s++)
          tags_busy = tags_busy | tag_v[s];
      end

      assign out_valid = tag_v[latency-1];
      assign out_id    = tag_id[latency-1];
    end
  endgenerate

  always_comb begin
    push = '0;
    pop  = '0;
    for (int unsigned i = 0; i < n_req; i++) begin
      push[i] = out_valid && (out_id == PW'(i));
      pop[i]  = resp_valid[i] && resp_ready[i];
    end
  end

  // Simultaneous push/pop on a full FIFO writes the slot being read; the head
  // is sampled before the write lands, so ordering holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < n_req; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
        for (int unsigned e = 0; e < fifo_depth; e++)
          mem[i][e] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < n_req; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= fu_res;
          wr_ptr[i]         <= ptr_inc(wr_ptr[i]);
        end
        if (pop[i])
          rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        if (push[i] && !pop[i])
          count[i] <= count[i] + CW'(1);
        else if (!push[i] && pop[i])
          count[i] <= count[i] - CW'(1);
      end
    end
  end

  always_comb begin
    resp_valid = '0;
    for (int unsigned i = 0; i < n_req; i++) begin
      resp_valid[i] = (count[i] != '0);
      resp_res[i]   = mem[i][rd_ptr[i]];
    end
    busy = tags_busy | (|resp_valid);
  end

endmodule
